m_fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the ID stage. It issues word reads to a synchronous instruction memory with one-cycle read latency and buffers the returned words with their PCs in a DEPTH-entry prefetch queue. It presents the queue head to decode through a valid/ready handshake. It handles branch redirects by flushing both the queue and any in-flight reads, and it stops issuing new reads while the core is halted.

---
 rtl/m_fetch_queue.sv | 154 +++++++++++++++
 tb/tb_m_fetch_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_fetch_queue.sv
// m_fetch_queue
// Instruction-fetch front end feeding the ID stage. It issues word reads to a
// synchronous instruction memory (one-cycle read latency) and buffers each
// returned word with its PC in a DEPTH-entry circular prefetch queue. The
// queue head is offered to decode through a valid/ready handshake. A
// redirect flushes the queue and any in-flight read. A halt stops new reads
// while already-issued reads still land in the queue.
//
// Ports:
//   w_clk        clock, all state updates on posedge
//   w_rst        synchronous active-high reset (dominates redirect and halt)
//   w_redir      redirect request from ID (branch taken)
//   w_redir_pc   redirect target, bits [1:0] ignored
//   w_halt       level; while high no new reads are issued
//   r_imem_addr  registered instruction-memory word address
//   r_imem_re    registered read strobe
//   w_imem_data  read data, valid the cycle after r_imem_re
//   w_id_ready   decode accepts the head entry this cycle
//   w_id_valid   head entry valid
//   w_id_ir      head instruction
//   w_id_pc      head PC
//   w_id_pc4     head PC + 4
//   r_count      queue occupancy
module m_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned AW       = 12
) (
   input  logic                       w_clk,
   input  logic                       w_rst,
   input  logic                       w_redir,
   input  logic [31:0]                w_redir_pc,
   input  logic                       w_halt,
   output logic [AW-1:0]              r_imem_addr,
   output logic                       r_imem_re,
   input  logic [31:0]                w_imem_data,
   input  logic                       w_id_ready,
   output logic                       w_id_valid,
   output logic [31:0]                w_id_ir,
   output logic [31:0]                w_id_pc,
   output logic [31:0]                w_id_pc4,
   output logic [$clog2(DEPTH):0]     r_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned DEPTH_I = DEPTH;
   // one extra bit so count + two in-flight reads never overflows
   localparam logic [CW:0] DEPTH_C = DEPTH_I[CW:0];

   logic [31:0]    r_fpc;
   logic [31:0]    r_req_pc;
   logic           r_resp_v;
   logic [31:0]    r_resp_pc;

   logic [31:0]    mem_pc_r [DEPTH];
   logic [31:0]    mem_ir_r [DEPTH];
   logic [PW-1:0]  head_r;
   logic [PW-1:0]  tail_r;

   logic [CW:0]    credit_s;
   logic           issue_s;
   logic           enq_s;
   logic           deq_s;
   logic [31:0]    target_s;

   // Head presentation; a redirect cycle masks the head so no dequeue happens.
   assign w_id_valid = (r_count != {CW{1'b0}}) & ~w_redir;
   assign w_id_ir    = mem_ir_r[head_r];
   assign w_id_pc    = mem_pc_r[head_r];
   assign w_id_pc4   = mem_pc_r[head_r] + 32'd4;

   // Issue credit counts queued entries plus the presented read and the
   // response on the bus; a same-cycle dequeue deliberately earns no credit.
   always_comb begin
      credit_s = {1'b0, r_count}
               + {{CW{1'b0}}, r_imem_re}
               + {{CW{1'b0}}, r_resp_v};
      issue_s  = ~w_halt & ~w_redir & (credit_s < DEPTH_C);
      enq_s    = r_resp_v & ~w_redir;
      deq_s    = w_id_valid & w_id_ready;
      target_s = w_redir_pc & 32'hFFFF_FFFC;
   end

   // Fetch PC, read request, response tracking and queue pointers/occupancy.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_fpc       <= RESET_PC;
         r_imem_re   <= 1'b0;
         r_imem_addr <= RESET_PC[AW+1:2];
         r_req_pc    <= RESET_PC;
         r_resp_v    <= 1'b0;
         r_resp_pc   <= RESET_PC;
         r_count     <= {CW{1'b0}};
         head_r      <= {PW{1'b0}};
         tail_r      <= {PW{1'b0}};
      end else if (w_redir) begin
         // flush: queue emptied and the word currently on the bus dropped
         r_count   <= {CW{1'b0}};
         head_r    <= {PW{1'b0}};
         tail_r    <= {PW{1'b0}};
         r_resp_v  <= 1'b0;
         r_resp_pc <= r_req_pc;
         if (!w_halt) begin
            r_imem_re   <= 1'b1;
            r_imem_addr <= target_s[AW+1:2];
            r_req_pc    <= target_s;
            r_fpc       <= target_s + 32'd4;
         end else begin
            // target is remembered and fetched once halt drops
            r_imem_re <= 1'b0;
            r_fpc     <= target_s;
         end
      end else begin
         if (issue_s) begin
            r_imem_re   <= 1'b1;
            r_imem_addr <= r_fpc[AW+1:2];
            r_req_pc    <= r_fpc;
            r_fpc       <= r_fpc + 32'd4;
         end else begin
            r_imem_re <= 1'b0;
         end
         r_resp_v  <= r_imem_re;
         r_resp_pc <= r_req_pc;
         if (enq_s) begin
            tail_r <= tail_r + PW'(1);
         end else begin
            tail_r <= tail_r;
         end
         if (deq_s) begin
            head_r <= head_r + PW'(1);
         end else begin
            head_r <= head_r;
         end
         case ({enq_s, deq_s})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage; returned word is written at the tail with its PC.
   always_ff @(posedge w_clk) begin
      if (!w_rst && enq_s) begin
         mem_pc_r[tail_r] <= r_resp_pc;
         mem_ir_r[tail_r] <= w_imem_data;
      end else begin
         mem_pc_r[tail_r] <= mem_pc_r[tail_r];
         mem_ir_r[tail_r] <= mem_ir_r[tail_r];
      end
   end

endmodule

// File: tb/tb_m_fetch_queue.sv
// Directed testbench for m_fetch_queue. The instruction memory returns
// 32'hA000_0000 + word address one cycle after the read strobe. Cycle 0 is
// the first cycle with reset low; inputs are driven and outputs sampled on
// the falling edge.
module tb_m_fetch_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 12;

   logic          w_clk = 1'b0;
   logic          w_rst;
   logic          w_redir;
   logic [31:0]   w_redir_pc;
   logic          w_halt;
   logic [AW-1:0] r_imem_addr;
   logic          r_imem_re;
   logic [31:0]   w_imem_data = 32'h0;
   logic          w_id_ready;
   logic          w_id_valid;
   logic [31:0]   w_id_ir;
   logic [31:0]   w_id_pc;
   logic [31:0]   w_id_pc4;
   logic [2:0]    r_count;

   int            cyc;
   int            n_cmp;
   int            n_mis;
   logic [31:0]   exp_pc;
   bit            sb_on;
   bit            resp_q;

   always #5 w_clk = ~w_clk;

   m_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .AW(AW)) dut (
      .w_clk(w_clk), .w_rst(w_rst), .w_redir(w_redir), .w_redir_pc(w_redir_pc),
      .w_halt(w_halt), .r_imem_addr(r_imem_addr), .r_imem_re(r_imem_re),
      .w_imem_data(w_imem_data), .w_id_ready(w_id_ready), .w_id_valid(w_id_valid),
      .w_id_ir(w_id_ir), .w_id_pc(w_id_pc), .w_id_pc4(w_id_pc4), .r_count(r_count)
   );

   // synchronous instruction memory, one-cycle latency
   always @(posedge w_clk) begin
      if (r_imem_re) w_imem_data <= 32'hA000_0000 + {20'h0, r_imem_addr};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // one clock: per-cycle scoreboard and no-enqueue-when-full check, then advance
   task automatic tick();
      bit nxt;
      #1;
      check("no_enq_full", 32'(resp_q & ~w_redir & ~w_rst & (r_count == 3'd4)), 32'd0);
      if (sb_on && w_id_valid && w_id_ready) begin
         check("sb_pc", w_id_pc, exp_pc);
         check("sb_ir", w_id_ir, 32'hA000_0000 + {20'h0, exp_pc[AW+1:2]});
         check("sb_pc4", w_id_pc4, exp_pc + 32'd4);
         exp_pc = exp_pc + 32'd4;
      end
      nxt = ~w_rst & r_imem_re & ~w_redir;
      @(posedge w_clk);
      resp_q = nxt;
      @(negedge w_clk);
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset();
      sb_on      = 1'b0;
      w_rst      = 1'b1;
      w_redir    = 1'b0;
      w_redir_pc = 32'h0;
      w_halt     = 1'b0;
      w_id_ready = 1'b1;
      tick();
      tick();
      w_rst  = 1'b0;
      resp_q = 1'b0;
      cyc    = 0;
   endtask

   // cycles 0..3 after reset release; returns in cycle 3
   task automatic startup();
      #1;
      check("c0_valid", 32'(w_id_valid), 32'd0);
      check("c0_re", 32'(r_imem_re), 32'd0);
      check("c0_count", 32'(r_count), 32'd0);
      check("c0_addr", 32'(r_imem_addr), 32'd0);
      sb_on  = 1'b1;
      exp_pc = 32'h0;
      tick();
      check("c1_re", 32'(r_imem_re), 32'd1);
      check("c1_addr", 32'(r_imem_addr), 32'd0);
      check("c1_valid", 32'(w_id_valid), 32'd0);
      tick();
      check("c2_re", 32'(r_imem_re), 32'd1);
      check("c2_addr", 32'(r_imem_addr), 32'd1);
      check("c2_valid", 32'(w_id_valid), 32'd0);
      tick();
      check("c3_valid", 32'(w_id_valid), 32'd1);
      check("c3_pc", w_id_pc, 32'h0);
      check("c3_ir", w_id_ir, 32'hA000_0000);
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      cyc   = 0;

      // 1: streaming, one instruction per cycle
      do_reset();
      startup();
      run_to(5);
      check("s1_count", 32'(r_count), 32'd1);
      check("s1_re", 32'(r_imem_re), 32'd1);
      run_to(13);
      check("s1_progress", exp_pc, 32'd40);

      // 2: backpressure cycles 3..12
      do_reset();
      startup();
      w_id_ready = 1'b0;
      run_to(6);
      check("bp_count6", 32'(r_count), 32'd4);
      check("bp_re6", 32'(r_imem_re), 32'd0);
      run_to(12);
      check("bp_count12", 32'(r_count), 32'd4);
      check("bp_re12", 32'(r_imem_re), 32'd0);
      check("bp_head", w_id_pc, 32'h0);
      run_to(13);
      w_id_ready = 1'b1;
      run_to(25);
      check("bp_progress", exp_pc, 32'd48);

      // 3: redirect to 0x40 in cycle 8
      do_reset();
      startup();
      run_to(8);
      check("rd_pre_pc", exp_pc, 32'd20);
      w_redir    = 1'b1;
      w_redir_pc = 32'h0000_0040;
      #1;
      check("rd_c8_valid", 32'(w_id_valid), 32'd0);
      tick();
      w_redir = 1'b0;
      exp_pc  = 32'h40;
      check("rd_c9_re", 32'(r_imem_re), 32'd1);
      check("rd_c9_addr", 32'(r_imem_addr), 32'h10);
      check("rd_c9_count", 32'(r_count), 32'd0);
      check("rd_c9_valid", 32'(w_id_valid), 32'd0);
      tick();
      check("rd_c10_valid", 32'(w_id_valid), 32'd0);
      tick();
      check("rd_c11_valid", 32'(w_id_valid), 32'd1);
      check("rd_c11_pc", w_id_pc, 32'h40);
      check("rd_c11_ir", w_id_ir, 32'hA000_0010);
      run_to(17);
      check("rd_progress", exp_pc, 32'h58);

      // 4: halt cycles 6..10
      do_reset();
      startup();
      run_to(6);
      w_halt = 1'b1;
      tick();
      check("h_c7_re", 32'(r_imem_re), 32'd0);
      tick();
      check("h_c8_valid", 32'(w_id_valid), 32'd1);
      check("h_c8_pc", w_id_pc, 32'd20);
      tick();
      check("h_c9_valid", 32'(w_id_valid), 32'd0);
      check("h_c9_count", 32'(r_count), 32'd0);
      tick();
      check("h_c10_valid", 32'(w_id_valid), 32'd0);
      check("h_c10_re", 32'(r_imem_re), 32'd0);
      tick();
      w_halt = 1'b0;
      tick();
      check("h_c12_re", 32'(r_imem_re), 32'd1);
      check("h_c12_addr", 32'(r_imem_addr), 32'd6);
      tick();
      check("h_c13_valid", 32'(w_id_valid), 32'd0);
      tick();
      check("h_c14_valid", 32'(w_id_valid), 32'd1);
      check("h_c14_pc", w_id_pc, 32'd24);
      run_to(19);
      check("h_progress", exp_pc, 32'd44);

      // 5: redirect to 0x103 (low bits ignored) while halted
      do_reset();
      startup();
      run_to(6);
      w_halt = 1'b1;
      run_to(8);
      w_redir    = 1'b1;
      w_redir_pc = 32'h0000_0103;
      #1;
      check("rh_c8_valid", 32'(w_id_valid), 32'd0);
      tick();
      w_redir = 1'b0;
      exp_pc  = 32'h100;
      check("rh_c9_count", 32'(r_count), 32'd0);
      check("rh_c9_valid", 32'(w_id_valid), 32'd0);
      for (int c = 9; c <= 13; c++) begin
         run_to(c);
         check("rh_no_read", 32'(r_imem_re), 32'd0);
      end
      w_halt = 1'b0;
      tick();
      check("rh_c14_re", 32'(r_imem_re), 32'd1);
      check("rh_c14_addr", 32'(r_imem_addr), 32'h40);
      tick();
      check("rh_c15_valid", 32'(w_id_valid), 32'd0);
      tick();
      check("rh_c16_valid", 32'(w_id_valid), 32'd1);
      check("rh_c16_pc", w_id_pc, 32'h100);
      check("rh_c16_ir", w_id_ir, 32'hA000_0040);

      // 6: reset mid-stream with three entries queued and a word on the bus
      do_reset();
      startup();
      w_id_ready = 1'b0;
      run_to(5);
      check("mr_count3", 32'(r_count), 32'd3);
      w_rst = 1'b1;
      sb_on = 1'b0;
      tick();
      check("mr_count", 32'(r_count), 32'd0);
      check("mr_valid", 32'(w_id_valid), 32'd0);
      check("mr_re", 32'(r_imem_re), 32'd0);
      w_rst      = 1'b0;
      w_id_ready = 1'b1;
      resp_q     = 1'b0;
      cyc        = 0;
      startup();
      run_to(8);
      check("mr_progress", exp_pc, 32'd20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
